npc_serial_alu: RTL and testbench
=================================

NPC_SERIAL_ALU -- requirements
Module: npc_serial_alu

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous active-high reset, rst.
REQ-002 Parameter WIDTH, default 16, SHALL set the operand width in bits; legal values are multiples of 4, minimum 4.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1, SHALL be the synchronous active-high reset.
REQ-005 Port start, input, 1, SHALL request an operation; it is accepted on a cycle where start=1 and ready=1.
REQ-006 Port m, input, 1, SHALL select the mode: 1 = arithmetic (carries active), 0 = logic.
REQ-007 Port s, input, 4, SHALL be the function select, s[0]..s[3].
REQ-008 Ports a and b, input, WIDTH each, SHALL be the operands.
REQ-009 Port ci, input, 1, SHALL be the active-high carry-in.
REQ-010 Port ready, output, 1, SHALL be high when a start is accepted this cycle.
REQ-011 Port done, output, 1, SHALL pulse for one cycle when the result is valid.
REQ-012 Port result, output, WIDTH, SHALL hold the last completed result.
REQ-013 Ports zf, co and ovf, output, 1 each, SHALL be the zero, carry-out and signed-overflow flags of the last result.

Function
REQ-014 On acceptance, a, b, s, m and ci SHALL be captured; later input changes SHALL NOT affect the operation.
REQ-015 The operation SHALL take one 4-bit slice per cycle, LSB slice first, for SLICES=WIDTH/4 cycles.
REQ-016 Per bit, the slice SHALL compute v=(a&~b&s0)|(a&b&s1) and u=a|(b&s2)|(~b&s3).
REQ-017 Each bit output SHALL be u^v^c, where c is the carry into that bit.
REQ-018 Each next carry SHALL be v|(u&c).
REQ-019 Every carry, including the slice carry-in, SHALL be forced to 0 when m=0.
REQ-020 The carry into slice 0 SHALL be ci&m, and the carry out of slice k SHALL be registered as the carry into slice k+1.
REQ-021 With m=1: s=0110 SHALL compute A+B+ci, and s=1001 SHALL compute A+~B+ci (ci=1 gives A-B); with m=0 and s=0110 the result SHALL be A^B.
REQ-022 The state machine SHALL have three states, IDLE, RUN and DONE.
REQ-023 Transitions: IDLE to RUN on accept; RUN to DONE after the last slice; DONE to RUN on accept, otherwise DONE to IDLE.
REQ-024 ready SHALL be 1 in IDLE and DONE and 0 in RUN.
REQ-025 start in RUN SHALL be ignored and not queued.
REQ-026 Latency SHALL be SLICES+1 cycles from the accept edge to done=1; done SHALL be high only in DONE.
REQ-027 result, zf, co and ovf SHALL update together on the cycle done rises and hold until the next done.
REQ-028 zf SHALL be 1 when result is all zeros.
REQ-029 co SHALL be the carry out of bit WIDTH-1 (0 when m=0).
REQ-030 ovf SHALL be the carry into bit WIDTH-1 XOR the carry out of it when m=1, and 0 when m=0.
REQ-031 Back-to-back: an accept in DONE SHALL start the next operation without an IDLE cycle.

Reset
REQ-032 rst SHALL force state IDLE, ready=1, done=0, result=0, zf=0, co=0, ovf=0, and clear the carry and slice-count registers.
REQ-033 rst during RUN SHALL abort the operation with no done pulse; rst has priority over start in the same cycle.

Structure
REQ-034 Package npc_alu_pkg SHALL hold the state enum and the named function-select constants FN_ADD=4'b0110 and FN_SUB=4'b1001.
REQ-035 The combinational 4-bit slice (v/u/carry/output, with slice carry-out and carry into bit 3) SHALL be sub-module npc_alu_slice, instantiated once and time-multiplexed.

Verification (WIDTH=16)
REQ-036 Add: a=0x00FF, b=0x0001, s=0110, m=1, ci=0 -> done 5 cycles after accept; result=0x0100, zf=0, co=0, ovf=0.
REQ-037 Subtract: a=b=0x1234, s=1001, m=1, ci=1 -> result=0x0000, zf=1, co=1, ovf=0.
REQ-038 Overflow: a=0x7FFF, b=0x0001, add, ci=0 -> result=0x8000, ovf=1, co=0.
REQ-039 Logic: a=0xF0F0, b=0xFF00, s=0110, m=0, ci=1 -> result=0x0FF0, co=0, ovf=0 (ci ignored).
REQ-040 Busy/reset: start pulsed in RUN -> ignored; rst asserted on the 2nd RUN cycle -> IDLE next cycle, no done, outputs zero.
REQ-041 Back-to-back: start held high from the DONE cycle -> second done exactly 5 cycles later; ready low throughout each RUN.

Source files
------------

// File: rtl/npc_alu_pkg.sv
// Shared types and constants for the nibble-serial ALU.
// FN_ADD and FN_SUB are the function-select codes for add and subtract.
package npc_alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] FN_ADD = 4'b0110;
  localparam logic [3:0] FN_SUB = 4'b1001;

endpackage

// File: rtl/npc_alu_slice.sv
// Combinational 4-bit ALU slice with a generate/propagate style carry chain.
// The top reuses this one slice on every cycle of an operation.
module npc_alu_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       cin,
  output logic [3:0] f,
  output logic       cout,
  output logic       c3
);

  logic [3:0] v;
  logic [3:0] u;
  logic [4:0] c;

  // When m=0 every carry is forced low, so the slice works bitwise in logic mode.
  always_comb begin
    v    = '0;
    u    = '0;
    f    = '0;
    c    = '0;
    c[0] = cin & m;
    for (int i = 0; i < 4; i++) begin
      v[i]     = (a[i] & ~b[i] & s[0]) | (a[i] & b[i] & s[1]);
      u[i]     = a[i] | (b[i] & s[2]) | (~b[i] & s[3]);
      f[i]     = u[i] ^ v[i] ^ c[i];
      c[i + 1] = (v[i] | (u[i] & c[i])) & m;
    end
    cout = c[4];
    c3   = c[3];
  end

endmodule

// File: rtl/npc_serial_alu.sv
// Nibble-serial ALU that processes one 4-bit slice per cycle, least significant slice first.
// It then spends one extra cycle publishing the result and flags together.
module npc_serial_alu
  import npc_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             m,
  input  logic [3:0]       s,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             co,
  output logic             ovf
);

  localparam int SLICES = WIDTH / 4;
  localparam int CNT_W  = $clog2(SLICES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SLICES);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic [3:0]       s_q;
  logic             m_q;
  logic             carry_q;
  logic             c3_q;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last;
  logic [3:0]       f_sl;
  logic             cout_sl;
  logic             c3_sl;

  assign ready  = (state != RUN);
  assign done   = (state == DONE);
  assign accept = start & ready;
  assign last   = (cnt == LAST);

  npc_alu_slice u_slice (
    .a    (a_q[3:0]),
    .b    (b_q[3:0]),
    .s    (s_q),
    .m    (m_q),
    .cin  (carry_q),
    .f    (f_sl),
    .cout (cout_sl),
    .c3   (c3_sl)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = RUN;
      RUN:     if (last) next_state = DONE;
      DONE:    next_state = accept ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operands shift down a nibble per slice; results enter acc from the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      carry_q <= 1'b0;
      c3_q    <= 1'b0;
      cnt     <= '0;
      result  <= '0;
      zf      <= 1'b0;
      co      <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        a_q     <= a;
        b_q     <= b;
        s_q     <= s;
        m_q     <= m;
        carry_q <= ci & m;
        c3_q    <= 1'b0;
        cnt     <= '0;
        acc     <= '0;
      end else if (state == RUN) begin
        if (!last) begin
          acc     <= (acc >> 4) | (WIDTH'(f_sl) << (WIDTH - 4));
          a_q     <= a_q >> 4;
          b_q     <= b_q >> 4;
          carry_q <= cout_sl;
          c3_q    <= c3_sl;
          cnt     <= cnt + 1'b1;
        end else begin
          result <= acc;
          zf     <= (acc == '0);
          co     <= carry_q;
          ovf    <= c3_q ^ carry_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_npc_serial_alu.sv
// Directed bench for npc_serial_alu at WIDTH=16, using a vector table and hand-written sequences.
// The sequences cover the busy, reset-abort and back-to-back cases.
module tb_npc_serial_alu;
  import npc_alu_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         m;
  logic [3:0]   s;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         ready;
  logic         done;
  logic [W-1:0] result;
  logic         zf;
  logic         co;
  logic         ovf;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  s;
    logic        m;
    logic        ci;
    logic [15:0] res;
    logic        zf;
    logic        co;
    logic        ovf;
  } vec_t;

  vec_t vecs[11];

  npc_serial_alu #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .m      (m),
    .s      (s),
    .a      (a),
    .b      (b),
    .ci     (ci),
    .ready  (ready),
    .done   (done),
    .result (result),
    .zf     (zf),
    .co     (co),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Counts edges until done is seen; ready must stay low until then.
  task automatic waitDone(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (done !== 1'b1) checkOutput("ready_low_in_run", 32'(ready), 32'd0);
    end
  endtask

  task automatic applyStimulus(input vec_t v, output int lat);
    @(negedge clk);
    a     = v.a;
    b     = v.b;
    s     = v.s;
    m     = v.m;
    ci    = v.ci;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = ~v.a;
    b     = ~v.b;
    ci    = ~v.ci;
    checkOutput("ready_after_accept", 32'(ready), 32'd0);
    waitDone(lat);
  endtask

  task automatic checkIdleQuiet(input string name, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen++;
    end
    checkOutput(name, 32'(seen), 32'd0);
  endtask

  initial begin
    int lat;
    vec_t v;

    vecs[0]  = '{16'h00FF, 16'h0001, FN_ADD,  1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{16'h1234, 16'h1234, FN_SUB,  1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{16'h7FFF, 16'h0001, FN_ADD,  1'b1, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{16'hF0F0, 16'hFF00, FN_ADD,  1'b0, 1'b1, 16'h0FF0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{16'hFFFF, 16'h0001, FN_ADD,  1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{16'h0005, 16'h0007, FN_SUB,  1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{16'h8000, 16'h0001, FN_SUB,  1'b1, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{16'h1234, 16'h1111, FN_ADD,  1'b1, 1'b1, 16'h2346, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{16'h0000, 16'h0000, FN_ADD,  1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{16'hF0F0, 16'hFF00, FN_SUB,  1'b0, 1'b1, 16'hF00F, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{16'h00FF, 16'h5A5A, 4'b0000, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    m     = 1'b0;
    s     = 4'h0;
    a     = '0;
    b     = '0;
    ci    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ready", 32'(ready), 32'd1);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_result", 32'(result), 32'd0);
    checkOutput("reset_flags", {29'd0, zf, co, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i], lat);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
      checkOutput($sformatf("vec%0d_result", i), 32'(result), 32'(vecs[i].res));
      checkOutput($sformatf("vec%0d_zf", i), 32'(zf), 32'(vecs[i].zf));
      checkOutput($sformatf("vec%0d_co", i), 32'(co), 32'(vecs[i].co));
      checkOutput($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
      checkOutput($sformatf("vec%0d_ready_in_done", i), 32'(ready), 32'd1);
    end

    // A start pulse during RUN must neither disturb the operation nor queue another one.
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; s = FN_ADD; m = 1'b1; ci = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1;
    a     = 16'hFFFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(lat);
    checkOutput("busy_latency", 32'(lat + 2), 32'd5);
    checkOutput("busy_result", 32'(result), 32'h0002);
    @(posedge clk);
    #1;
    checkOutput("busy_done_falls", 32'(done), 32'd0);
    checkOutput("busy_back_to_idle", 32'(ready), 32'd1);
    checkIdleQuiet("busy_no_queued_done", 8);

    // Reset on the second RUN cycle aborts the operation without a done pulse.
    @(negedge clk);
    a = 16'h0009; b = 16'h0003; s = FN_SUB; m = 1'b1; ci = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("abort_ready", 32'(ready), 32'd1);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_result", 32'(result), 32'd0);
    checkOutput("abort_flags", {29'd0, zf, co, ovf}, 32'd0);
    checkIdleQuiet("abort_no_done", 8);

    // Hold start high so the second operation is accepted on the DONE cycle.
    @(negedge clk);
    a = 16'h0003; b = 16'h0004; s = FN_ADD; m = 1'b1; ci = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    a = 16'h0010;
    b = 16'h0020;
    checkOutput("b2b_first_ready", 32'(ready), 32'd0);
    waitDone(lat);
    checkOutput("b2b_first_latency", 32'(lat), 32'd5);
    checkOutput("b2b_first_result", 32'(result), 32'h0007);
    @(posedge clk);
    #1;
    checkOutput("b2b_no_idle_gap", {30'd0, done, ready}, 32'd0);
    waitDone(lat);
    start = 1'b0;
    checkOutput("b2b_second_latency", 32'(lat), 32'd5);
    checkOutput("b2b_second_result", 32'(result), 32'h0030);
    @(posedge clk);
    #1;
    checkOutput("b2b_end_idle", {30'd0, done, ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
